// File: rtl/leds_pio_arbiter.sv
// Round-robin Avalon-MM arbiter letting two requesters share one zero-wait LED PIO slave.
// Latency: fixed 3 cycles per transaction (grant in IDLE, ACCESS, ack in RESP), one in flight.
// Backpressure: requests are level-held until ack; a requester losing a tie waits in IDLE.
module leds_pio_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_readdata,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_readdata,
    output logic [1:0]        grant,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_nxt;
    logic   last_grant;     // index of the most recently served requester
    logic   start;
    logic   win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                start = r0_req | r1_req;
                win   = (r0_req & r1_req) ? ~last_grant : r1_req;
                if (start) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant       <= 2'b00;
            address     <= '0;
            writedata   <= '0;
            chipselect  <= 1'b0;
            write_n     <= 1'b1;
            r0_ack      <= 1'b0;
            r1_ack      <= 1'b0;
            r0_readdata <= '0;
            r1_readdata <= '0;
            last_grant  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        grant      <= win ? 2'b10 : 2'b01;
                        address    <= win ? r1_address : r0_address;
                        writedata  <= win ? r1_writedata : r0_writedata;
                        write_n    <= win ? ~r1_write : ~r0_write;
                        chipselect <= 1'b1;
                    end
                end
                ACCESS: begin
                    chipselect <= 1'b0;
                    write_n    <= 1'b1;
                    r0_ack     <= grant[0];
                    r1_ack     <= grant[1];
                    // write_n still carries the latched direction during ACCESS
                    if (write_n) begin
                        if (grant[0]) r0_readdata <= readdata;
                        if (grant[1]) r1_readdata <= readdata;
                    end
                end
                default: begin
                    r0_ack     <= 1'b0;
                    r1_ack     <= 1'b0;
                    grant      <= 2'b00;
                    last_grant <= grant[1];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leds_pio_arbiter.sv
// Testbench for leds_pio_arbiter: directed scenarios plus random two-requester traffic,
// checked every cycle against a transaction-level model of the arbiter and LED PIO.
module tb_leds_pio_arbiter;

    logic        clk;
    logic        reset_n;
    logic        r0_req, r0_write, r1_req, r1_write;
    logic [1:0]  r0_address, r1_address;
    logic [31:0] r0_writedata, r1_writedata;
    logic        r0_ack, r1_ack;
    logic [31:0] r0_readdata, r1_readdata;
    logic [1:0]  grant;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;

    int n_tests = 0;
    int n_fail  = 0;

    leds_pio_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_write(r0_write), .r0_address(r0_address),
        .r0_writedata(r0_writedata), .r0_ack(r0_ack), .r0_readdata(r0_readdata),
        .r1_req(r1_req), .r1_write(r1_write), .r1_address(r1_address),
        .r1_writedata(r1_writedata), .r1_ack(r1_ack), .r1_readdata(r1_readdata),
        .grant(grant), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LED PIO slave: one data register at address 0, everything else reads 0
    logic [31:0] pio_reg = 32'd0;
    always_ff @(posedge clk)
        if (chipselect && !write_n && address == 2'd0) pio_reg <= writedata;
    assign readdata = (address == 2'd0) ? pio_reg : 32'd0;

    // Transaction-level reference: m_age = cycles elapsed since the grant decision
    int          m_age, m_own, m_last;
    logic        m_w;
    logic [1:0]  m_a;
    logic [31:0] m_d;
    logic [31:0] m_rd [2];
    logic [31:0] m_port = 32'd0;
    logic        hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_own = 0; m_last = 1;
        m_w = 1'b0; m_a = 2'd0; m_d = 32'd0;
        m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    endtask

    task automatic model_step();
        if (m_age == 0) begin
            if (r0_req || r1_req) begin
                m_own = (r0_req && r1_req) ? 1 - m_last : (r1_req ? 1 : 0);
                m_w   = (m_own == 1) ? r1_write : r0_write;
                m_a   = (m_own == 1) ? r1_address : r0_address;
                m_d   = (m_own == 1) ? r1_writedata : r0_writedata;
                m_age = 1;
            end
        end else if (m_age == 1) begin
            if (!m_w)              m_rd[m_own] = (m_a == 2'd0) ? m_port : 32'd0;
            else if (m_a == 2'd0)  m_port = m_d;
            m_age = 2;
        end else begin
            m_last = m_own;
            m_age  = 0;
        end
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("grant", 32'(grant), (m_age != 0) ? (32'd1 << m_own) : 32'd0);
        check("chipselect", 32'(chipselect), 32'(m_age == 1));
        check("write_n", 32'(write_n), 32'(!(m_age == 1 && m_w)));
        check("r0_ack", 32'(r0_ack), 32'(m_age == 2 && m_own == 0));
        check("r1_ack", 32'(r1_ack), 32'(m_age == 2 && m_own == 1));
        if (m_age == 1) begin
            check("address", 32'(address), 32'(m_a));
            check("writedata", writedata, m_d);
        end
        check("r0_readdata", r0_readdata, m_rd[0]);
        check("r1_readdata", r1_readdata, m_rd[1]);
        check("pio_reg", pio_reg, m_port);
        if (!hold) begin
            if (r0_ack) r0_req = 1'b0;
            if (r1_ack) r1_req = 1'b0;
        end
    endtask

    initial begin
        int cs_cnt;
        int k;
        logic just0, just1;
        reset_n = 1'b1;
        r0_req = 0; r0_write = 0; r0_address = 0; r0_writedata = 0;
        r1_req = 0; r1_write = 0; r1_address = 0; r1_writedata = 0;
        #1 reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_chipselect", 32'(chipselect), 32'd0);
        check("rst_write_n", 32'(write_n), 32'd1);
        check("rst_grant", 32'(grant), 32'd0);
        reset_n = 1'b1;
        repeat (5) cycle();

        // r0 write 0x2AAA to the LED register
        r0_req = 1; r0_write = 1; r0_address = 2'd0; r0_writedata = 32'h0000_2AAA;
        cycle();
        check("wr_cs", 32'(chipselect), 32'd1);
        check("wr_data", writedata, 32'h0000_2AAA);
        cycle();
        check("wr_ack", 32'(r0_ack), 32'd1);
        cycle();
        check("wr_pio", pio_reg, 32'h0000_2AAA);

        // r1 reads it back; r0_readdata untouched
        r1_req = 1; r1_write = 0; r1_address = 2'd0;
        repeat (3) cycle();
        check("rd_r1", r1_readdata, 32'h0000_2AAA);
        check("rd_r0_hold", r0_readdata, 32'd0);

        // Constant dual requests: strict alternation, one transaction every 3 cycles
        hold = 1'b1;
        r0_req = 1; r0_write = 1; r0_address = 0; r0_writedata = 32'h1;
        r1_req = 1; r1_write = 1; r1_address = 0; r1_writedata = 32'h2;
        cs_cnt = 0; k = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (chipselect) cs_cnt++;
            if (r0_ack || r1_ack) begin
                check("rr_order", 32'(r1_ack), 32'(k % 2));
                k++;
            end
        end
        check("cs_duty", 32'(cs_cnt), 32'd4);
        hold = 1'b0;
        r0_req = 0; r1_req = 0;
        cycle();

        // Unmapped read, with req dropped during ACCESS
        r1_req = 1; r1_write = 0; r1_address = 2'd1;
        cycle();
        r1_req = 0;
        cycle();
        check("drop_ack", 32'(r1_ack), 32'd1);
        cycle();
        check("unmapped_rd", r1_readdata, 32'd0);

        // Reset during ACCESS of an r0 write
        r0_req = 1; r0_write = 1; r0_address = 0; r0_writedata = 32'h55;
        cycle();
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_cs", 32'(chipselect), 32'd0);
        check("rst_mid_wn", 32'(write_n), 32'd1);
        check("rst_mid_ack", 32'(r0_ack), 32'd0);
        model_reset();
        r0_req = 0;
        #3 reset_n = 1'b1;
        r1_req = 1; r1_write = 0; r1_address = 0;
        cycle();
        check("post_rst_grant", 32'(grant), 32'd2);
        repeat (2) cycle();

        // Random traffic
        just0 = 0; just1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!r0_req && !just0 && $urandom_range(0, 2) == 0) begin
                r0_req = 1; r0_write = 1'($urandom_range(0, 1));
                r0_address = 2'($urandom_range(0, 3)); r0_writedata = $urandom;
            end else if (r0_req && grant[0]) begin
                if ($urandom_range(0, 9) == 0) r0_req = 0;
                if ($urandom_range(0, 4) == 0) begin
                    r0_address = 2'($urandom_range(0, 3)); r0_writedata = $urandom;
                end
            end
            if (!r1_req && !just1 && $urandom_range(0, 2) == 0) begin
                r1_req = 1; r1_write = 1'($urandom_range(0, 1));
                r1_address = 2'($urandom_range(0, 3)); r1_writedata = $urandom;
            end else if (r1_req && grant[1]) begin
                if ($urandom_range(0, 9) == 0) r1_req = 0;
                if ($urandom_range(0, 4) == 0) begin
                    r1_address = 2'($urandom_range(0, 3)); r1_writedata = $urandom;
                end
            end
            cycle();
            just0 = r0_ack; just1 = r1_ack;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/leds_pio_arbiter.md
Name: leds_pio_arbiter

Overview:
- Avalon-MM master-side arbiter that lets two requesters share the single LED PIO slave, e.g. the Nios software bridge and the hardware game-logic status path.
- Each requester issues one read or one write per request/ack handshake.
- The block serialises accesses with a round-robin policy and drives the PIO slave's chipselect/write_n/address/writedata.
- Sits between the requesters and the LED PIO; the PIO is zero-wait-state, with combinational readdata.

Parameters:
- DATA_W, 32, data width of writedata/readdata on all sides.
- ADDR_W, 2, slave word-address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- r0_req  in  1  requester 0 request; level, held until r0_ack
- r0_write  in  1  1 = write, 0 = read; stable while r0_req high
- r0_address  in  ADDR_W  requester 0 slave address
- r0_writedata  in  DATA_W  requester 0 write data
- r0_ack  out  1  one-cycle completion pulse to requester 0
- r0_readdata  out  DATA_W  read result for requester 0; valid with r0_ack
- r1_req, r1_write, r1_address, r1_writedata, r1_ack, r1_readdata: same as requester 0, for requester 1
- grant  out  2  one-hot owner of the transaction in flight; 00 when idle
- address  out  ADDR_W  to PIO slave
- chipselect  out  1  to PIO slave
- write_n  out  1  to PIO slave, active low
- writedata  out  DATA_W  to PIO slave
- readdata  in  DATA_W  from PIO slave; combinational on address

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0):
  - state=IDLE
  - chipselect=0, write_n=1, address=0, writedata=0
  - grant=00, r0_ack=r1_ack=0, r0_readdata=r1_readdata=0
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles.
- IDLE:
  - No req: stay in IDLE, outputs idle.
  - Exactly one req: grant it.
  - Both req: grant the requester that is not last_grant.
  - On grant, register the winner's address, writedata and write into the master-side registers, set grant one-hot, and go to ACCESS.
- ACCESS (one cycle):
  - chipselect=1; write_n = ~latched write; address/writedata hold the latched values.
  - For a read, sample readdata at the end of this cycle into the granted requester's rN_readdata register.
  - Go to RESP.
- RESP (one cycle):
  - chipselect=0, write_n=1.
  - Pulse the granted rN_ack=1; set last_grant to the granted index; clear grant to 00.
  - Go to IDLE.
- Read data:
  - rN_readdata updates only on that requester's reads.
  - It holds its value across writes and across the other requester's transactions.
- Request handshake:
  - The requester must deassert req in the cycle after ack.
  - A req still high in the IDLE cycle after RESP counts as a new request.
  - A single continuous requester is therefore served once every 3 cycles.
- Req dropped mid-transaction (ACCESS/RESP): the transaction still completes and ack still pulses. No abort.
- Req changes (address/data/write) after grant are ignored; the values latched in IDLE are used.
- Fairness: under constant dual requests, grants strictly alternate 0,1,0,1…
- Never more than one rN_ack high in a cycle. chipselect is high only in ACCESS.
- Reset mid-ACCESS: chipselect drops and write_n rises immediately (asynchronously). No ack is issued. After release, the FSM is in IDLE and re-arbitrates from last_grant=1.
- Address outside the PIO register map is passed through unchanged. The PIO returns 0 on reads and ignores writes to it; the arbiter does not check.
- Widths: data passes through unchanged at DATA_W. No arithmetic.

Test Plan:
- Reset, then idle for 5 cycles -> chipselect=0, write_n=1, grant=00, both acks 0, both readdata=0.
- r0 write addr=0 data=0x0000_2AAA -> ACCESS cycle shows chipselect=1, write_n=0, address=0, writedata=0x2AAA; r0_ack pulses 2 cycles after grant; PIO out_port=0x2AAA.
- r1 read addr=0 after the previous write -> r1_readdata=0x0000_2AAA with r1_ack; r0_readdata stays 0.
- r0 and r1 both held high with writes 0x0001/0x0002 for 12 cycles -> grant order 0,1,0,1; one transaction every 3 cycles; chipselect duty exactly 1 in 3.
- r1 read addr=1 -> r1_readdata=0 (unmapped address); r1 drops req during ACCESS -> r1_ack still pulses once.
- Assert reset_n=0 during ACCESS of an r0 write -> chipselect=0 the same cycle, no r0_ack; after release, an r1-only request is granted first.
